lcg_stim_gen: RTL and testbench

Synthesizable stimulus source for the fuzz `top` DUT. It reproduces, bit-exactly, the bench's 32-bit LCG (state = state*0x41C64E6D + 0x3039 mod 2^32) and packs successive LCG words into the DUT's flat input vector. It sits directly upstream of the `top` in_flat port. Vectors are offered over a valid/ready handshake so the same stream can drive the DUT on-chip or feed a capture FIFO.

---
 rtl/lcg_stim_pkg.sv | 22 ++
 rtl/lcg_stim_gen.sv | 115 +++++++++++
 tb/tb_lcg_stim_gen.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcg_stim_pkg.sv
// Shared definitions for the LCG stimulus generator: the LCG constants,
// the single-step function and the control FSM state encoding.
package lcg_stim_pkg;

    localparam logic [31:0] LCG_MUL = 32'h41C6_4E6D;
    localparam logic [31:0] LCG_INC = 32'h0000_3039;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GEN     = 2'd1,
        PRESENT = 2'd2,
        FIN     = 2'd3
    } state_t;

    // One LCG step: the product is truncated to 32 bits and the add wraps.
    function automatic logic [31:0] lcg_next(input logic [31:0] cur);
        logic [31:0] prod;
        prod = cur * LCG_MUL;
        return prod + LCG_INC;
    endfunction

endpackage

// File: rtl/lcg_stim_gen.sv
// LCG stimulus generator. Each vector is built from NWORDS successive LCG
// states, one per cycle, and then offered on a valid/ready handshake.
// The LCG state survives runs, aborts and done, so consecutive runs
// continue one unbroken sequence until a seed load or a reset.
module lcg_stim_gen
    import lcg_stim_pkg::*;
#(
    parameter int          OUT_W    = 142,
    parameter logic [31:0] DEF_SEED = 32'd1053874332
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             seed_load,
    input  logic [31:0]      seed_in,
    input  logic             start,
    input  logic [31:0]      num_vectors,
    input  logic             abort,
    output logic             vec_valid,
    input  logic             vec_ready,
    output logic [OUT_W-1:0] vec_data,
    output logic             busy,
    output logic             done,
    output logic [31:0]      vec_count
);

    localparam int NWORDS = (OUT_W + 31) / 32;
    localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

    state_t           state;
    logic [31:0]      lcg;
    logic [31:0]      lcg_nxt;
    logic [IDX_W-1:0] word_idx;
    logic [31:0]      remaining;
    logic             word_write;
    logic             handshake;

    assign lcg_nxt    = lcg_next(lcg);
    assign word_write = (state == GEN) && !abort;
    assign handshake  = (state == PRESENT) && vec_ready;

    assign vec_valid  = (state == PRESENT);
    assign busy       = (state != IDLE);
    assign done       = (state == FIN);

    // Control path: FSM, LCG state, word index and the run counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            lcg       <= DEF_SEED;
            word_idx  <= '0;
            remaining <= '0;
            vec_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (seed_load) begin
                        lcg <= seed_in;
                    end
                    if (start) begin
                        remaining <= num_vectors;
                        vec_count <= '0;
                        word_idx  <= '0;
                        state     <= (num_vectors == 32'd0) ? FIN : GEN;
                    end
                end
                GEN: begin
                    if (abort) begin
                        state <= IDLE;
                    end else begin
                        lcg <= lcg_nxt;
                        if (word_idx == LAST_IDX) begin
                            word_idx <= '0;
                            state    <= PRESENT;
                        end else begin
                            word_idx <= word_idx + 1'b1;
                        end
                    end
                end
                PRESENT: begin
                    if (handshake) begin
                        vec_count <= vec_count + 32'd1;
                        remaining <= remaining - 32'd1;
                    end
                    if (abort) begin
                        state <= IDLE;
                    end else if (handshake) begin
                        state <= (remaining == 32'd1) ? FIN : GEN;
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Data path: drop the fresh LCG state into the word slot being built;
    // bits past OUT_W in the last word simply have no destination.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_data <= '0;
        end else if (word_write) begin
            for (int b = 0; b < OUT_W; b++) begin
                if ((b / 32) == int'(word_idx)) begin
                    vec_data[b] <= lcg_nxt[b % 32];
                end
            end
        end
    end

endmodule

// File: tb/tb_lcg_stim_gen.sv
// Scoreboard bench for lcg_stim_gen: expected vectors come from an
// independent software LCG and are queued when a run starts; a monitor on
// the falling edge pops and compares every accepted vector.
module tb_lcg_stim_gen;

    localparam int          OUT_W    = 142;
    localparam logic [31:0] DEF_SEED = 32'd1053874332;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             seed_load = 1'b0;
    logic [31:0]      seed_in = '0;
    logic             start = 1'b0;
    logic [31:0]      num_vectors = '0;
    logic             abort = 1'b0;
    logic             vec_valid;
    logic             vec_ready = 1'b0;
    logic [OUT_W-1:0] vec_data;
    logic             busy;
    logic             done;
    logic [31:0]      vec_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int last_accept_cyc = -1;
    bit check_spacing = 1'b0;
    bit rand_mode = 1'b0;
    bit hold_pending = 1'b0;
    logic [OUT_W-1:0] held_data;
    logic [OUT_W-1:0] sb[$];
    logic [31:0] model_lcg;

    lcg_stim_gen #(.OUT_W(OUT_W), .DEF_SEED(DEF_SEED)) dut (
        .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed_in(seed_in),
        .start(start), .num_vectors(num_vectors), .abort(abort),
        .vec_valid(vec_valid), .vec_ready(vec_ready), .vec_data(vec_data),
        .busy(busy), .done(done), .vec_count(vec_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [159:0] actual,
                                input logic [159:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: timed out waiting", name);
    endtask

    function automatic logic [31:0] model_step(input logic [31:0] s);
        longint unsigned t;
        t = (longint'(s) * 64'd1103515245 + 64'd12345) & 64'hFFFF_FFFF;
        return t[31:0];
    endfunction

    task automatic next_vector(output logic [OUT_W-1:0] v);
        logic [159:0] w;
        w = '0;
        for (int k = 0; k < 5; k++) begin
            model_lcg = model_step(model_lcg);
            w[32*k +: 32] = model_lcg;
        end
        v = w[OUT_W-1:0];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic do_seed, input logic [31:0] seed,
                                  input logic [31:0] n);
        logic [OUT_W-1:0] v;
        if (do_seed) model_lcg = seed;
        for (int i = 0; i < int'(n); i++) begin
            next_vector(v);
            sb.push_back(v);
        end
        last_accept_cyc = -1;
        seed_load   = do_seed;
        seed_in     = seed;
        num_vectors = n;
        start       = 1'b1;
        tick();
        seed_load = 1'b0;
        start     = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output int waited);
        waited = 0;
        while (!vec_valid && waited < budget) begin
            tick();
            waited++;
        end
        if (!vec_valid) timeout_fail("wait_valid");
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        if (busy) timeout_fail("wait_idle");
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, "_valid"}, 160'(vec_valid), 160'd0);
        check_output({tag, "_busy"}, 160'(busy), 160'd0);
        check_output({tag, "_done"}, 160'(done), 160'd0);
        check_output({tag, "_count"}, 160'(vec_count), 160'd0);
        check_output({tag, "_data"}, 160'(vec_data), 160'd0);
    endtask

    // Monitor: compare accepted vectors, stall stability, spacing; count done pulses.
    always @(negedge clk) begin
        logic [OUT_W-1:0] exp_v;
        if (rst_n && vec_valid) begin
            if (hold_pending) check_output("stall_stable", 160'(vec_data), 160'(held_data));
            if (vec_ready) begin
                if (sb.size() == 0) begin
                    timeout_fail("unexpected_vector");
                end else begin
                    exp_v = sb.pop_front();
                    check_output("vector", 160'(vec_data), 160'(exp_v));
                end
                if (check_spacing && last_accept_cyc >= 0)
                    check_output("spacing", 160'(cyc - last_accept_cyc), 160'd6);
                last_accept_cyc = cyc;
                hold_pending = 1'b0;
            end else begin
                hold_pending = 1'b1;
                held_data = vec_data;
            end
        end else begin
            hold_pending = 1'b0;
        end
        if (done) done_cnt++;
    end

    // Random backpressure: ready drops for bursts of 1..20 cycles.
    initial begin
        int stall_left = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rand_mode) begin
                if (stall_left > 0) begin
                    vec_ready = 1'b0;
                    stall_left--;
                end else begin
                    vec_ready = 1'b1;
                    if ($urandom_range(0, 2) == 0) stall_left = int'($urandom_range(1, 20));
                end
            end
        end
    end

    initial begin
        int waited;
        int d0;
        logic [OUT_W-1:0] dummy;

        // Reset values.
        tick();
        tick();
        check_reset_values("reset");
        rst_n = 1'b1;
        tick();

        // Seed 0, single vector.
        vec_ready = 1'b0;
        d0 = done_cnt;
        apply_stimulus(1'b1, 32'd0, 32'd1);
        wait_valid(50, waited);
        check_output("seed0_latency", 160'(waited), 160'd5);
        check_output("seed0_w0", 160'(vec_data[31:0]), 160'h0000_3039);
        check_output("seed0_w1", 160'(vec_data[63:32]), 160'hD3DC_167E);
        vec_ready = 1'b1;
        wait_idle(50);
        check_output("seed0_done", 160'(done_cnt - d0), 160'd1);
        check_output("seed0_count", 160'(vec_count), 160'd1);

        // Default seed, 201 vectors at full throughput.
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
        model_lcg = DEF_SEED;
        d0 = done_cnt;
        check_spacing = 1'b1;
        apply_stimulus(1'b0, 32'd0, 32'd201);
        wait_idle(2000);
        check_spacing = 1'b0;
        check_output("def_done", 160'(done_cnt - d0), 160'd1);
        check_output("def_count", 160'(vec_count), 160'd201);
        check_output("def_drain", 160'(sb.size()), 160'd0);

        // Random backpressure.
        rand_mode = 1'b1;
        apply_stimulus(1'b1, 32'h1234_5678, 32'd20);
        wait_idle(5000);
        rand_mode = 1'b0;
        tick();
        vec_ready = 1'b1;
        check_output("bp_count", 160'(vec_count), 160'd20);
        check_output("bp_drain", 160'(sb.size()), 160'd0);

        // Zero-length run.
        d0 = done_cnt;
        apply_stimulus(1'b0, 32'd0, 32'd0);
        check_output("zero_busy", 160'(busy), 160'd1);
        check_output("zero_done", 160'(done), 160'd1);
        check_output("zero_valid", 160'(vec_valid), 160'd0);
        tick();
        check_output("zero_idle", 160'(busy), 160'd0);
        check_output("zero_count", 160'(vec_count), 160'd0);
        check_output("zero_pulses", 160'(done_cnt - d0), 160'd1);

        // Abort during GEN.
        d0 = done_cnt;
        apply_stimulus(1'b1, 32'hDEAD_0001, 32'd2);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_output("abort_gen_busy", 160'(busy), 160'd0);
        check_output("abort_gen_valid", 160'(vec_valid), 160'd0);
        sb.delete();
        tick();
        check_output("abort_gen_nodone", 160'(done_cnt - d0), 160'd0);

        // Abort coincident with a handshake in PRESENT, then continue.
        vec_ready = 1'b0;
        d0 = done_cnt;
        apply_stimulus(1'b1, 32'hCAFE_F00D, 32'd3);
        wait_valid(50, waited);
        vec_ready = 1'b1;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        vec_ready = 1'b0;
        check_output("abort_pr_busy", 160'(busy), 160'd0);
        check_output("abort_pr_count", 160'(vec_count), 160'd1);
        check_output("abort_pr_nodone", 160'(done_cnt - d0), 160'd0);
        sb.delete();
        model_lcg = 32'hCAFE_F00D;
        next_vector(dummy);
        vec_ready = 1'b1;
        apply_stimulus(1'b0, 32'd0, 32'd1);
        wait_idle(50);
        check_output("continue_drain", 160'(sb.size()), 160'd0);
        check_output("continue_count", 160'(vec_count), 160'd1);

        // Reset mid-PRESENT, then replay the default-seed sequence.
        vec_ready = 1'b0;
        apply_stimulus(1'b1, 32'h0BAD_BEEF, 32'd3);
        wait_valid(50, waited);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_values("midreset");
        sb.delete();
        model_lcg = DEF_SEED;
        #1;
        rst_n = 1'b1;
        tick();
        vec_ready = 1'b1;
        apply_stimulus(1'b0, 32'd0, 32'd2);
        wait_idle(100);
        check_output("replay_drain", 160'(sb.size()), 160'd0);
        check_output("replay_count", 160'(vec_count), 160'd2);

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
